// File: rtl/axis_layer_serializer_pkg.sv
// Shared types and header layout for the layer-to-AXI-Stream serializer.
// FRAME_HDR_EN adds the header state to the FSM encoding.
package layer_stream_pkg;

`ifdef FRAME_HDR_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HDR    = 2'd1,
    ST_STREAM = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd2
  } state_e;
`endif

  localparam int HDR_NCH_W   = 8;
  localparam int HDR_CNT_W   = 16;
  localparam int HDR_CNT_LSB = 0;
  localparam int HDR_NCH_LSB = HDR_CNT_LSB + HDR_CNT_W;
  localparam int HDR_W       = HDR_NCH_LSB + HDR_NCH_W;

  // Header beat: {channel count, frame counter}; caller zero-pads to the bus width.
  function automatic logic [HDR_W-1:0] hdr_word(input logic [HDR_NCH_W-1:0] nch,
                                                input logic [HDR_CNT_W-1:0] cnt);
    logic [HDR_W-1:0] w;
    w = '0;
    w[HDR_NCH_LSB +: HDR_NCH_W] = nch;
    w[HDR_CNT_LSB +: HDR_CNT_W] = cnt;
    return w;
  endfunction

endpackage

// File: rtl/axis_layer_serializer_if.sv
// AXI4-Stream bundle between the serializer (master) and its sink (slave).
interface axis_layer_serializer_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/layer_capture_bank.sv
// N_CH x DATA_W holding bank: parallel load of all channels, indexed read of one word.
module layer_capture_bank #(
  parameter int N_CH   = 18,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   load_i,
  input  logic [N_CH*DATA_W-1:0] data_i,
  input  logic [IDX_W-1:0]       idx_i,
  output logic [DATA_W-1:0]      word_o
);

  logic [DATA_W-1:0] mem_q [N_CH];

  // NOTE: the bank has no reset; its contents are only observed after a load.
  always_ff @(posedge clk) begin
    if (load_i) begin
      for (int i = 0; i < N_CH; i++) mem_q[i] <= data_i[i*DATA_W +: DATA_W];
    end
  end

  // NOTE: default assigned first so out-of-range indices cannot infer a latch.
  always_comb begin
    word_o = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (idx_i == IDX_W'(i)) word_o = mem_q[i];
    end
  end

endmodule

// File: rtl/axis_layer_serializer.sv
// Captures N_CH channel words on the rising edge of all-done and streams them as one
// AXI4-Stream frame with TLAST. Optional header beat when FRAME_HDR_EN is defined.
module axis_layer_serializer
  import layer_stream_pkg::*;
#(
  parameter int N_CH   = 18,
  parameter int DATA_W = 32,
  parameter int OVR_W  = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [N_CH*DATA_W-1:0] ch_data,
  input  logic [N_CH-1:0]        ch_done,
  axis_layer_serializer_if.master m_axis,
  output logic                   busy,
  output logic                   overrun,
  output logic [OVR_W-1:0]       ovr_count
);

  localparam int              IDX_W    = $clog2(N_CH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);
`ifdef FRAME_HDR_EN
  localparam state_e START_ST = ST_HDR;
`else
  localparam state_e START_ST = ST_STREAM;
`endif

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               done_q;
  logic               overrun_q;
  logic [OVR_W-1:0]   ovr_count_q, ovr_count_d;
  logic               frame_edge, tvalid, hs, at_last, last_hs, accept, drop;
  logic [DATA_W-1:0]  bank_word;
`ifdef FRAME_HDR_EN
  logic [HDR_CNT_W-1:0] frame_cnt_q;
`endif

  layer_capture_bank #(.N_CH(N_CH), .DATA_W(DATA_W), .IDX_W(IDX_W)) u_bank (
    .clk    (clk),
    .load_i (accept),
    .data_i (ch_data),
    .idx_i  (idx_q),
    .word_o (bank_word)
  );

  always_comb begin
    frame_edge = (&ch_done) & ~done_q;
    tvalid     = (state_q != ST_IDLE);
    hs         = tvalid & m_axis.tready;
    at_last    = (state_q == ST_STREAM) && (idx_q == LAST_IDX);
    last_hs    = hs & at_last;
    // The bank is free when idle or when its last word leaves this very cycle.
    accept     = frame_edge & ((state_q == ST_IDLE) | last_hs);
    drop       = frame_edge & ~accept;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ovr_count_d = ovr_count_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = START_ST;
          idx_d   = '0;
        end
      end
`ifdef FRAME_HDR_EN
      ST_HDR: begin
        if (hs) state_d = ST_STREAM;
      end
`endif
      ST_STREAM: begin
        if (hs) begin
          if (at_last) begin
            state_d = accept ? START_ST : ST_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (drop && (ovr_count_q != '1)) ovr_count_d = ovr_count_q + OVR_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      ovr_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      done_q      <= &ch_done;
      overrun_q   <= overrun_q | drop;
      ovr_count_q <= ovr_count_d;
    end
  end

`ifdef FRAME_HDR_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      frame_cnt_q <= '0;
    else if (last_hs) frame_cnt_q <= frame_cnt_q + HDR_CNT_W'(1);
  end
`endif

  // tdata is forced to zero when idle so the bus never shows stale bank contents.
  always_comb begin
    m_axis.tdata = '0;
    if (state_q == ST_STREAM) m_axis.tdata = bank_word;
`ifdef FRAME_HDR_EN
    if (state_q == ST_HDR) m_axis.tdata = DATA_W'(hdr_word(HDR_NCH_W'(N_CH), frame_cnt_q));
`endif
  end

  assign m_axis.tvalid = tvalid;
  assign m_axis.tlast  = at_last;
  assign busy          = tvalid;
  assign overrun       = overrun_q;
  assign ovr_count     = ovr_count_q;

endmodule

// File: tb/tb_axis_layer_serializer.sv
// Directed bench for axis_layer_serializer; handles builds with or without FRAME_HDR_EN.
module tb_axis_layer_serializer;
  localparam int N_CH   = 18;
  localparam int DATA_W = 32;
  localparam int OVR_W  = 8;
`ifdef FRAME_HDR_EN
  localparam int NB = N_CH + 1;
`else
  localparam int NB = N_CH;
`endif

  logic                   clk = 1'b0;
  logic                   resetn;
  logic [N_CH*DATA_W-1:0] ch_data;
  logic [N_CH-1:0]        ch_done;
  logic                   busy, overrun;
  logic [OVR_W-1:0]       ovr_count;
  int                     n_total = 0;
  int                     n_bad   = 0;
  int                     exp_cnt = 0;

  axis_layer_serializer_if #(.DATA_W(DATA_W)) axis ();

  axis_layer_serializer #(.N_CH(N_CH), .DATA_W(DATA_W), .OVR_W(OVR_W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .ch_data   (ch_data),
    .ch_done   (ch_done),
    .m_axis    (axis),
    .busy      (busy),
    .overrun   (overrun),
    .ovr_count (ovr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] base, input int beat, input int cnt);
`ifdef FRAME_HDR_EN
    if (beat == 0) return {8'h00, 8'(N_CH), 16'(cnt)};
    return base + 32'(beat - 1);
`else
    return base + 32'(beat) + 32'(cnt) * 0;
`endif
  endfunction

  task automatic set_data(input logic [31:0] base);
    for (int i = 0; i < N_CH; i++) ch_data[i*DATA_W +: DATA_W] = base + 32'(i);
  endtask

  // Called at a negedge while idle: load channel words and raise all done flags.
  task automatic fire(input logic [31:0] base);
    set_data(base);
    ch_done = '1;
    check("pre_edge_tvalid", 32'(axis.tvalid), 32'd0);
    @(negedge clk);
  endtask

  // Receives one frame; mode 0 always ready, 1 toggling, 2 random. Optionally drops and
  // re-raises ch_done (with new data) at cycles glitch_at / glitch_at+1.
  task automatic recv_frame(input logic [31:0] base, input int mode, input int glitch_at,
                            input logic [31:0] new_base);
    int beat = 0;
    int cyc  = 0;
    while (beat < NB && cyc < 400) begin
      case (mode)
        0:       axis.tready = 1'b1;
        1:       axis.tready = (cyc % 2 == 0);
        default: axis.tready = 1'($urandom_range(0, 1));
      endcase
      check("tvalid", 32'(axis.tvalid), 32'd1);
      check("busy", 32'(busy), 32'd1);
      check("tdata", axis.tdata, exp_word(base, beat, exp_cnt));
      check("tlast", 32'(axis.tlast), 32'(beat == NB - 1));
      if (axis.tvalid && axis.tready) beat++;
      if (cyc == glitch_at) ch_done = '0;
      if (cyc == glitch_at + 1) begin
        set_data(new_base);
        ch_done = '1;
      end
      @(negedge clk);
      cyc++;
    end
    check("frame_complete", 32'(beat), 32'(NB));
    exp_cnt++;
    axis.tready = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tvalid"}, 32'(axis.tvalid), 32'd0);
    check({tag, "_tlast"}, 32'(axis.tlast), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_tdata"}, axis.tdata, 32'd0);
  endtask

  initial begin
    resetn      = 1'b0;
    ch_done     = '0;
    ch_data     = '0;
    axis.tready = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset");
    check("reset_overrun", 32'(overrun), 32'd0);
    check("reset_ovr_count", 32'(ovr_count), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // 1: plain frame, always ready
    set_data(32'h100);
    fire(32'h100);
    recv_frame(32'h100, 0, -1, 32'h0);
    check_idle("t1_end");
    check("t1_overrun", 32'(overrun), 32'd0);

    // 2: toggling then random back-pressure
    ch_done = '0;
    @(negedge clk);
    fire(32'h200);
    recv_frame(32'h200, 1, -1, 32'h0);
    check_idle("t2a_end");
    ch_done = '0;
    @(negedge clk);
    fire(32'h300);
    recv_frame(32'h300, 2, -1, 32'h0);
    check_idle("t2b_end");

    // 3: second edge mid-stream is dropped, frame unaltered
    ch_done = '0;
    @(negedge clk);
    fire(32'h400);
    recv_frame(32'h400, 0, 5, 32'h500);
    check_idle("t3_end");
    check("t3_overrun", 32'(overrun), 32'd1);
    check("t3_ovr_count", 32'(ovr_count), 32'd1);
    // ch_done still high: no new frame may start
    repeat (3) @(negedge clk);
    check("t3_held_done_tvalid", 32'(axis.tvalid), 32'd0);

    // 4: edge coincident with last-beat handshake, next frame without a gap
    ch_done = '0;
    @(negedge clk);
    fire(32'h5A0);
    recv_frame(32'h5A0, 0, NB - 2, 32'h600);
    recv_frame(32'h600, 0, -1, 32'h0);
    check_idle("t4_end");
    check("t4_ovr_count", 32'(ovr_count), 32'd1);

    // 5: reset at beat 7, then a fresh frame restarts at word 0
    ch_done = '0;
    @(negedge clk);
    fire(32'h700);
    for (int b = 0; b < 7; b++) begin
      check("t5_pre_tdata", axis.tdata, exp_word(32'h700, b, exp_cnt));
      @(negedge clk);
    end
    check("t5_beat7", axis.tdata, exp_word(32'h700, 7, exp_cnt));
    resetn = 1'b0;
    #1;
    check_idle("t5_reset");
    check("t5_reset_overrun", 32'(overrun), 32'd0);
    check("t5_reset_ovr_count", 32'(ovr_count), 32'd0);
    ch_done = '0;
    exp_cnt = 0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    fire(32'h800);
    recv_frame(32'h800, 0, -1, 32'h0);
    check_idle("t5_end");

    // 6: another frame; with the header enabled this checks the counter advancing
    ch_done = '0;
    @(negedge clk);
    fire(32'h900);
    recv_frame(32'h900, 0, -1, 32'h0);
    check_idle("t6_end");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
